// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multi-cycle multiply/divide sequencer for the EX stage and the
// sole producer of computed HI/LO values. MULT/MULTU use a shift-add loop and
// DIV/DIVU use a restoring loop, each running ITER iterations. MTHI/MTLO
// complete in one cycle with no stall.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             aborts any operation and masks write enables
//   stall_i           EX held by a later stage; holds results in DONE
//   op_i              0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 none
//   src1_i, src2_i    rs / rt operands
//   stallreq_o        combinational EX stall request
//   busy_o            sequencer not idle
//   hi_we_o, lo_we_o  HI/LO write enables
//   hi_o, lo_o        HI/LO write data
module hilo_md_ctrl #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        stallreq_o,
  output logic        busy_o,
  output logic        hi_we_o,
  output logic        lo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CW = $clog2(ITER);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t       r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [63:0]  r_acc;      // product accumulator or remainder
  logic [31:0]  r_quo;
  logic [31:0]  r_mag1;     // multiplicand / dividend magnitude
  logic [31:0]  r_mag2;     // multiplier / divisor magnitude
  logic [31:0]  r_raw1;     // unmodified src1 for the divide-by-zero result
  logic         r_is_div;
  logic         r_neg_res;  // negate product / quotient
  logic         r_neg_rem;  // remainder follows the dividend sign
  logic         r_div0;
  logic [31:0]  r_hi, r_lo;

  logic         w_is_md, w_signed, w_start;
  logic [31:0]  w_abs1, w_abs2;
  logic [63:0]  w_mul_acc, w_rem_sh, w_rem_nxt, w_prod;
  logic         w_ge;
  logic [31:0]  w_quo_f, w_rem_f, w_fix_hi, w_fix_lo;

  assign w_is_md  = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                    (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign w_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign w_start  = (r_state == S_IDLE) && w_is_md && !flush;
  assign w_abs1   = (w_signed && src1_i[31]) ? 32'd0 - src1_i : src1_i;
  assign w_abs2   = (w_signed && src2_i[31]) ? 32'd0 - src2_i : src2_i;

  // One shift-add multiply step
  assign w_mul_acc = r_acc + (r_mag2[r_cnt] ? ({32'd0, r_mag1} << r_cnt) : 64'd0);

  // One restoring divide step, dividend bits consumed MSB-first
  assign w_rem_sh  = {r_acc[62:0], r_mag1[CW'(ITER - 1) - r_cnt]};
  assign w_ge      = (w_rem_sh >= {32'd0, r_mag2});
  assign w_rem_nxt = w_ge ? (w_rem_sh - {32'd0, r_mag2}) : w_rem_sh;

  // Sign fix-up and special cases
  assign w_prod  = r_neg_res ? (64'd0 - r_acc) : r_acc;
  assign w_quo_f = r_neg_res ? (32'd0 - r_quo) : r_quo;
  assign w_rem_f = r_neg_rem ? (32'd0 - r_acc[31:0]) : r_acc[31:0];

  always_comb begin
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_fix_hi = r_raw1;
        w_fix_lo = 32'hFFFF_FFFF;
      end else begin
        w_fix_hi = w_rem_f;
        w_fix_lo = w_quo_f;
      end
    end
  end

  // Next state and outputs
  always_comb begin
    w_next     = r_state;
    stallreq_o = 1'b0;
    hi_we_o    = 1'b0;
    lo_we_o    = 1'b0;
    hi_o       = r_hi;
    lo_o       = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_is_md) begin
          w_next     = S_CALC;
          stallreq_o = 1'b1;
        end else if (op_i == OP_MTHI) begin
          hi_we_o = 1'b1;
          hi_o    = src1_i;
        end else if (op_i == OP_MTLO) begin
          lo_we_o = 1'b1;
          lo_o    = src1_i;
        end
      end
      S_CALC: begin
        stallreq_o = 1'b1;
        if (r_cnt == CW'(ITER - 1)) w_next = S_FIX;
      end
      S_FIX: begin
        stallreq_o = 1'b1;
        w_next     = S_DONE;
      end
      S_DONE: begin
        hi_we_o = 1'b1;
        lo_we_o = 1'b1;
        if (!stall_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Flush wins over everything, including MTHI/MTLO and DONE writes
    if (flush) begin
      w_next     = S_IDLE;
      stallreq_o = 1'b0;
      hi_we_o    = 1'b0;
      lo_we_o    = 1'b0;
    end
  end

  assign busy_o = (r_state != S_IDLE);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_quo     <= '0;
      r_mag1    <= '0;
      r_mag2    <= '0;
      r_raw1    <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt     <= '0;
        r_acc     <= '0;
        r_quo     <= '0;
        r_mag1    <= w_abs1;
        r_mag2    <= w_abs2;
        r_raw1    <= src1_i;
        r_is_div  <= (op_i == OP_DIV) || (op_i == OP_DIVU);
        r_neg_res <= w_signed && (src1_i[31] ^ src2_i[31]);
        r_neg_rem <= w_signed && src1_i[31];
        r_div0    <= (src2_i == 32'd0);
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_is_div) begin
          r_acc <= w_rem_nxt;
          r_quo <= {r_quo[30:0], w_ge};
        end else begin
          r_acc <= w_mul_acc;
        end
      end
      if ((r_state == S_FIX) && !flush) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Testbench for hilo_md_ctrl: directed cases plus randomized mul/div operations
// compared against an arithmetic reference model.
module tb_hilo_md_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, stall_i;
  logic [2:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic        stallreq_o, busy_o, hi_we_o, lo_we_o;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_md_ctrl #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_i(stall_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .stallreq_o(stallreq_o), .busy_o(busy_o),
    .hi_we_o(hi_we_o), .lo_we_o(lo_we_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [3:0] ctl();
    return {stallreq_o, busy_o, hi_we_o, lo_we_o};
  endfunction

  // Reference: {hi, lo} from plain arithmetic on the architectural operands
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] r;
    int q, m;
    r = '0;
    case (op)
      3'd1: r = 64'(longint'($signed(a)) * longint'($signed(b)));
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r = {32'(m), 32'(q)};
        end
      end
      3'd4: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue one mul/div at the current cycle N and check every cycle through IDLE
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_v,
                        input int stall_n, input bit hold);
    op_i = op; src1_i = a; src2_i = b;
    @(negedge clk);
    chk({tag, ":accept"}, 64'(ctl()), 64'(4'b1000));
    tick;
    if (!hold) op_i = 3'd0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      chk({tag, ":busy"}, 64'(ctl()), 64'(4'b1100));
      tick;
    end
    for (int d = 0; d <= stall_n; d++) begin
      stall_i = (d < stall_n);
      @(negedge clk);
      chk({tag, ":done_ctl"}, 64'(ctl()), 64'(4'b0111));
      chk({tag, ":result"}, {hi_o, lo_o}, exp_v);
      tick;
    end
    op_i = 3'd0; stall_i = 1'b0;
    @(negedge clk);
    chk({tag, ":idle"}, 64'(ctl()), 64'(4'b0000));
    tick;
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    rst = 1'b1; flush = 1'b0; stall_i = 1'b0; op_i = 3'd0; src1_i = '0; src2_i = '0;
    tick; tick;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", 64'(ctl()), 64'(4'b0000));
    chk("reset_data", {hi_o, lo_o}, 64'd0);
    tick;

    // MTLO / MTHI, with and without flush
    op_i = 3'd6; src1_i = 32'h1234;
    @(negedge clk);
    chk("mtlo_ctl", 64'(ctl()), 64'(4'b0001));
    chk("mtlo_data", 64'(lo_o), 64'h1234);
    tick;
    op_i = 3'd5; src1_i = 32'hCAFE_F00D; flush = 1'b1;
    @(negedge clk);
    chk("mthi_flush_ctl", 64'(ctl()), 64'(4'b0000));
    tick;
    flush = 1'b0;
    @(negedge clk);
    chk("mthi_ctl", 64'(ctl()), 64'(4'b0010));
    chk("mthi_data", 64'(hi_o), 64'hCAFE_F00D);
    tick;
    op_i = 3'd0;

    // Directed arithmetic cases
    run_op("divu_100_7", 3'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 1'b0);
    run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 1'b0);
    run_op("mult_m3_5", 3'd1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b0);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0);
    run_op("divu_by0", 3'd4, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0, 1'b0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0, 1'b0);
    run_op("div_neg_by0", 3'd3, 32'hFFFF_FFF7, 32'd0, {32'hFFFF_FFF7, 32'hFFFF_FFFF}, 0, 1'b0);
    run_op("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0, 1'b0);

    // Flush mid-divide, then a new MULTU right behind it
    op_i = 3'd3; src1_i = 32'd1000; src2_i = 32'd3;
    @(negedge clk);
    chk("flush:accept", 64'(ctl()), 64'(4'b1000));
    tick;
    op_i = 3'd0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("flush:busy", 64'(ctl()), 64'(4'b1100));
      tick;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush:during", 64'(ctl()), 64'(4'b0100));
    tick;
    flush = 1'b0;
    run_op("after_flush", 3'd2, 32'd3, 32'd4, 64'd12, 0, 1'b0);

    // DONE held by stall_i with the op still present
    run_op("stall_hold", 3'd1, 32'd7, 32'd6, 64'd42, 3, 1'b1);

    // Synchronous reset mid-operation clears state and results
    op_i = 3'd4; src1_i = 32'd50; src2_i = 32'd3;
    tick;
    op_i = 3'd0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", 64'(ctl()), 64'(4'b0000));
    chk("midrst_data", {hi_o, lo_o}, 64'd0);
    tick;

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(1, 4));
      case ($urandom_range(0, 5))
        0: r_a = 32'h8000_0000;
        1: r_a = 32'hFFFF_FFFF;
        2: r_a = 32'd0;
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: r_b = 32'd0;
        1: r_b = 32'hFFFF_FFFF;
        2: r_b = 32'd1;
        3: r_b = 32'($urandom_range(2, 300));
        default: r_b = $urandom;
      endcase
      run_op("rand", r_op, r_a, r_b, model(r_op, r_a, r_b), $urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
